decoration_sequencer: RTL
=========================

# decoration_sequencer

Controller that walks a four-slot opcode program for the decoration breadboard and dispatches each decoded opcode to the colour, sound or movement actuator over a req/ack handshake. After each accepted action it holds the effect for a fixed number of cycles, then advances. It sits between the host-loaded program word and the actuator units. It replaces the free-running slot counter and mux with a sequenced, handshaked scheduler.

## Interface
- HOLD_CYCLES, 4: cycles an accepted effect is held before the next slot; must be ≥1.
- ACK_TIMEOUT, 16: maximum cycles to wait for an ack; used only with DECOR_WATCHDOG_EN.
- clk  in  1: the only clock; all state changes on its rising edge.
- rst  in  1: reset, asynchronous and active-low.
- program  in  [3:0][3:0]: slot opcodes; program[n] is slot n.
- start  in  1: single-cycle pulse that begins a pass at slot 0; ignored while busy.
- loop  in  1: 1 = wrap from slot 3 to slot 0 and continue; 0 = stop after slot 3.
- stop  in  1: abort; forces IDLE on the next edge.
- clr_err  in  1: clears err.
- act_ack  in  [2:0]: per-actuator ack; bit 0 colour, bit 1 sound, bit 2 movement.
- act_req  out  [2:0]: one-hot request, registered.
- act_code  out  [1:0]: opcode[1:0] of the current request; valid while act_req≠0.
- slot  out  [1:0]: slot being executed.
- busy  out  1: high in every state except IDLE.
- err  out  1: sticky flag for an invalid opcode (or a timeout, with the watchdog).

## Operation
- Opcode class is op[3:2]: 00 system, 01 colour, 10 sound, 11 movement. Code is op[1:0].
- States are IDLE, FETCH, REQ, HOLD.
- IDLE: on start, set slot to 0 and go to FETCH.
- FETCH: latch op = program[slot], then decode it:
  - System 00 (ON): no-op; advance.
  - System 01 (RESET): clear act_req, set slot to 0, go to IDLE.
  - System 10/11: reserved; no-op; advance.
  - Actuator class with code 11: invalid; set err, skip, advance.
  - Other actuator opcodes: go to REQ with act_req = one-hot(class−1) and act_code = code.
- REQ: hold act_req and act_code stable until act_ack for that class is sampled high. On that edge, clear act_req, load the hold counter with HOLD_CYCLES−1, and go to HOLD. Acks on other bits are ignored.
- HOLD: decrement the counter; at 0, advance.
- Advance:
  - slot<3: slot+1, go to FETCH.
  - slot=3 and loop=1: slot=0, go to FETCH.
  - slot=3 and loop=0: go to IDLE.
- stop beats every other event. It clears act_req and the counter and goes to IDLE. slot holds its value.
- clr_err and a new error in the same cycle: err=1.

## Timing
- Reset values: state IDLE; act_req=000, act_code=00, slot=00, busy=0, err=0, hold counter 0.
- Reset asserted mid-operation drops act_req asynchronously.
- start sampled at edge 0:
  - FETCH during cycle 1.
  - act_req high from cycle 2.
- Ack that is already high: req is high for exactly 1 cycle. Then HOLD_CYCLES cycles, then FETCH of the next slot.
- Actuator slot cost with immediate ack: 2+HOLD_CYCLES cycles. No-op or invalid slot: 1 cycle (FETCH only).
- Program changes take effect at the next FETCH; the latched op is never re-read.

## Configuration
- Macro DECOR_WATCHDOG_EN.
- Defined: a counter runs in REQ. After ACK_TIMEOUT cycles without ack, the block drops act_req, sets err, skips HOLD and advances.
- Undefined: REQ waits indefinitely, and ACK_TIMEOUT is unused.

## Structure
- Shared package decor_pkg holds:
  - State enum.
  - Class constants CLS_SYS/CLS_COLOR/CLS_SOUND/CLS_MOVE.
  - Opcode constants ON=0000, RESET=0001, GREEN=0100, PURPLE=0101, ORANGE=0110, SCREAMING=1000, CACKLING=1001, BOO=1010, WAVEHANDS=1100, MOVEJAW=1101, FOG=1110.
- One sub-module, decor_hold_timer: loadable down-counter with a done flag. It is reused for the watchdog.

## Test plan
- Full pass: program slots {0000, 0101, 1010, 1101}, loop=0, acks tied high, HOLD_CYCLES=4, start pulse.
  - act_req pulses 001/01, then 010/10, then 100/01, each followed by 4 hold cycles.
  - busy falls after slot 3; err=0.
- Delayed ack: slot 1=0110, act_ack[0] raised 5 cycles after the req. act_req=001 with code 10 stays stable all 5 cycles and falls the cycle after the ack is sampled.
- Invalid and RESET:
  - Slot 1=0111: err=1, no request issued.
  - Slot 2=0001: IDLE with slot=0; slot 3 is never fetched.
  - clr_err pulse: err=0.
- Loop and stop:
  - loop=1: slot goes 3→0 without a start pulse.
  - stop asserted mid-REQ: act_req=000 and busy=0 on the next edge.
- Reset mid-HOLD: drive rst low asynchronously. All outputs go to reset values immediately; the block stays in IDLE until a start after rst returns high.
- With DECOR_WATCHDOG_EN, ACK_TIMEOUT=16, ack never given: act_req drops after 16 cycles, err=1, and the next slot is fetched.

Source files
------------

// File: rtl/decor_pkg.sv
// Shared types and constants for the decoration sequencer.
// Opcode layout: op[3:2] is the class, op[1:0] is the code.
package decor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_REQ   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] CLS_SYS   = 2'b00;
  localparam logic [1:0] CLS_COLOR = 2'b01;
  localparam logic [1:0] CLS_SOUND = 2'b10;
  localparam logic [1:0] CLS_MOVE  = 2'b11;

  localparam logic [1:0] SYS_RESET_CODE = 2'b01;
  localparam logic [1:0] INVALID_CODE   = 2'b11;

  localparam logic [3:0] ON        = 4'b0000;
  localparam logic [3:0] RESET     = 4'b0001;
  localparam logic [3:0] GREEN     = 4'b0100;
  localparam logic [3:0] PURPLE    = 4'b0101;
  localparam logic [3:0] ORANGE    = 4'b0110;
  localparam logic [3:0] SCREAMING = 4'b1000;
  localparam logic [3:0] CACKLING  = 4'b1001;
  localparam logic [3:0] BOO       = 4'b1010;
  localparam logic [3:0] WAVEHANDS = 4'b1100;
  localparam logic [3:0] MOVEJAW   = 4'b1101;
  localparam logic [3:0] FOG       = 4'b1110;

  // Actuator class to request line: colour=bit0, sound=bit1, movement=bit2.
  function automatic logic [2:0] cls_onehot(input logic [1:0] cls);
    case (cls)
      CLS_COLOR: cls_onehot = 3'b001;
      CLS_SOUND: cls_onehot = 3'b010;
      CLS_MOVE:  cls_onehot = 3'b100;
      default:   cls_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/decor_hold_timer.sv
// Loadable down-counter with a done flag (count == 0).
// Used for the effect hold time and, with DECOR_WATCHDOG_EN, the ack watchdog.
module decor_hold_timer
  import decor_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Clear beats load beats decrement; the count saturates at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    r_cnt <= '0;
    else if (i_clr)                  r_cnt <= '0;
    else if (i_load)                 r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/decoration_sequencer.sv
// Decoration sequencer: walks a four-slot opcode program and dispatches each
// actuator opcode over a one-hot req/ack handshake, then holds the effect.
// Optional macro DECOR_WATCHDOG_EN: bounds the ack wait to ACK_TIMEOUT cycles,
// flagging err and skipping the slot on expiry.
module decoration_sequencer
  import decor_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [3:0][3:0] i_program,
  input  logic            i_start,
  input  logic            i_loop,
  input  logic            i_stop,
  input  logic            i_clr_err,
  input  logic [2:0]      i_act_ack,
  output logic [2:0]      o_act_req,
  output logic [1:0]      o_act_code,
  output logic [1:0]      o_slot,
  output logic            o_busy,
  output logic            o_err
);

  // Timer is sized for the larger of the two loads so the width does not
  // change between builds with and without the watchdog.
  localparam int TMR_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
`ifdef DECOR_WATCHDOG_EN
  localparam logic [TW-1:0] ACK_LOAD  = TW'(ACK_TIMEOUT - 1);
`endif

  state_t        r_state;
  logic [3:0]    r_op;
  logic [1:0]    r_slot;
  logic [2:0]    r_act_req;
  logic          r_err;

  logic [3:0]    w_op;
  logic [1:0]    w_cls;
  logic [1:0]    w_code;
  logic          w_fetch_act;
  logic          w_fetch_inv;
  logic          w_hit;
  logic          w_done;
  logic          w_timeout;
  logic          w_err_set;
  state_t        w_adv_state;
  logic [1:0]    w_adv_slot;
  logic          w_tmr_load;
  logic [TW-1:0] w_tmr_val;
  logic          w_tmr_dec;

  // The program word is only looked at during FETCH; REQ works from r_op.
  assign w_op        = i_program[r_slot];
  assign w_cls       = w_op[3:2];
  assign w_code      = w_op[1:0];
  assign w_fetch_act = (r_state == ST_FETCH) && (w_cls != CLS_SYS) && (w_code != INVALID_CODE);
  assign w_fetch_inv = (r_state == ST_FETCH) && (w_cls != CLS_SYS) && (w_code == INVALID_CODE);

  // Ack is honoured only on the bit belonging to the latched opcode's class.
  always_comb begin
    w_hit = 1'b0;
    case (r_op[3:2])
      CLS_COLOR: w_hit = i_act_ack[0];
      CLS_SOUND: w_hit = i_act_ack[1];
      CLS_MOVE:  w_hit = i_act_ack[2];
      default:   w_hit = 1'b0;
    endcase
  end

`ifdef DECOR_WATCHDOG_EN
  assign w_timeout = (r_state == ST_REQ) && !w_hit && w_done;
`else
  assign w_timeout = 1'b0;
`endif

  assign w_err_set = !i_stop && (w_fetch_inv || w_timeout);

  // Next slot/state when the current slot is finished.
  always_comb begin
    w_adv_slot  = r_slot + 2'd1;
    w_adv_state = ST_FETCH;
    if (r_slot == 2'd3) begin
      w_adv_slot  = i_loop ? 2'd0 : r_slot;
      w_adv_state = i_loop ? ST_FETCH : ST_IDLE;
    end
  end

  // Timer control: hold load on ack, count down in HOLD (and in REQ as watchdog).
  always_comb begin
    w_tmr_load = (r_state == ST_REQ) && w_hit;
    w_tmr_val  = HOLD_LOAD;
    w_tmr_dec  = (r_state == ST_HOLD);
`ifdef DECOR_WATCHDOG_EN
    if (w_fetch_act) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = ACK_LOAD;
    end
    if (r_state == ST_REQ) w_tmr_dec = 1'b1;
`endif
  end

  decor_hold_timer #(.W(TW)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (i_stop),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_done     (w_done)
  );

  // Sticky error: a new error wins over a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
    else if (i_clr_err) r_err <= 1'b0;
  end

  // Sequencer FSM; stop overrides every other transition and keeps slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_slot    <= '0;
      r_act_req <= '0;
    end else if (i_stop) begin
      r_state   <= ST_IDLE;
      r_act_req <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_slot  <= 2'd0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_op <= w_op;
          if (w_cls == CLS_SYS && w_code == SYS_RESET_CODE) begin
            r_act_req <= '0;
            r_slot    <= 2'd0;
            r_state   <= ST_IDLE;
          end else if (w_fetch_act) begin
            r_act_req <= cls_onehot(w_cls);
            r_state   <= ST_REQ;
          end else begin
            r_slot  <= w_adv_slot;
            r_state <= w_adv_state;
          end
        end
        ST_REQ: begin
          if (w_hit) begin
            r_act_req <= '0;
            r_state   <= ST_HOLD;
          end else if (w_timeout) begin
            r_act_req <= '0;
            r_slot    <= w_adv_slot;
            r_state   <= w_adv_state;
          end
        end
        ST_HOLD: begin
          if (w_done) begin
            r_slot  <= w_adv_slot;
            r_state <= w_adv_state;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_act_req  = r_act_req;
  assign o_act_code = r_op[1:0];
  assign o_slot     = r_slot;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_err      = r_err;

endmodule
